// File: rtl/usb3_rx_os_ctl.sv
// RX ordered-set controller: parses word-aligned TS1/TS2 sets from the descrambler,
// tracks runs of identical sets and latches scrambling off after a qualified TS2 run.
module usb3_rx_os_ctl #(
  parameter int TS2_THRESH = 8,
  parameter int CNT_W      = 4
) (
  input  logic             local_clk,
  input  logic             reset_n,
  input  logic [31:0]      proc_data,
  input  logic [3:0]       proc_datak,
  input  logic             proc_active,
  input  logic             err_skp_unexpected,
  input  logic             link_reset,
  output logic             scr_enable,
  output logic             ts1_det,
  output logic             ts2_det,
  output logic [7:0]       link_func,
  output logic [CNT_W-1:0] run_cnt,
  output logic [CNT_W-1:0] skp_err_cnt
);

  localparam logic [7:0]       IDENT_TS1 = 8'h4A;
  localparam logic [7:0]       IDENT_TS2 = 8'h45;
  localparam logic [7:0]       SYM_COM   = 8'hBC;
  localparam logic [CNT_W-1:0] THRESH    = CNT_W'(TS2_THRESH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, HDR, BODY1, BODY2} state_t;

  state_t           state, state_nxt;
  logic [7:0]       cap_ident, cap_func, prev_ident;
  logic [CNT_W-1:0] run_inc, run_nxt;
  logic             is_w0, is_w1, is_body;
  logic             do_capture, do_classify, do_malformed;
  logic             skp_prev;

  // proc_active is a valid-only qualifier: a word is consumed on every cycle it is
  // high and there is no ready/backpressure path; low cycles simply hold the parse.
  assign is_w0   = (proc_datak == 4'hF) && (proc_data == {4{SYM_COM}});
  assign is_w1   = (proc_datak == 4'h0) && (proc_data[7:0] == 8'h00) &&
                   (proc_data[23:16] == proc_data[31:24]) &&
                   ((proc_data[31:24] == IDENT_TS1) || (proc_data[31:24] == IDENT_TS2));
  assign is_body = (proc_datak == 4'h0) && (proc_data == {4{cap_ident}});

  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n)        state <= IDLE;
    else if (link_reset) state <= IDLE;
    else                 state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    do_capture   = 1'b0;
    do_classify  = 1'b0;
    do_malformed = 1'b0;
    if (proc_active) begin
      case (state)
        IDLE: if (is_w0) state_nxt = HDR;
        HDR: begin
          if (is_w1) begin
            do_capture = 1'b1;
            state_nxt  = BODY1;
          end else if (!is_w0) begin
            do_malformed = 1'b1;
          end
        end
        BODY1: begin
          if (is_body) state_nxt = BODY2;
          else         do_malformed = 1'b1;
        end
        BODY2: begin
          if (is_body) begin
            do_classify = 1'b1;
            state_nxt   = IDLE;
          end else begin
            do_malformed = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
      // A broken set may itself be the header of the next one.
      if (do_malformed) state_nxt = is_w0 ? HDR : IDLE;
    end
  end

  assign run_inc = (&run_cnt) ? run_cnt : run_cnt + CNT_ONE;
  assign run_nxt = ((cap_ident == prev_ident) && (cap_func == link_func)) ? run_inc : CNT_ONE;

  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n) begin
      scr_enable <= 1'b1;
      ts1_det    <= 1'b0;
      ts2_det    <= 1'b0;
      link_func  <= 8'h00;
      run_cnt    <= '0;
      cap_ident  <= 8'h00;
      cap_func   <= 8'h00;
      prev_ident <= 8'h00;
    end else if (link_reset) begin
      scr_enable <= 1'b1;
      ts1_det    <= 1'b0;
      ts2_det    <= 1'b0;
      link_func  <= 8'h00;
      run_cnt    <= '0;
      cap_ident  <= 8'h00;
      cap_func   <= 8'h00;
      prev_ident <= 8'h00;
    end else begin
      ts1_det <= 1'b0;
      ts2_det <= 1'b0;
      if (do_capture) begin
        cap_ident <= proc_data[31:24];
        cap_func  <= proc_data[15:8];
      end
      if (do_classify) begin
        ts1_det    <= (cap_ident == IDENT_TS1);
        ts2_det    <= (cap_ident == IDENT_TS2);
        link_func  <= cap_func;
        prev_ident <= cap_ident;
        run_cnt    <= run_nxt;
        // Threshold uses the post-increment count; once cleared it stays cleared.
        if ((cap_ident == IDENT_TS2) && cap_func[3] && (run_nxt >= THRESH))
          scr_enable <= 1'b0;
      end else if (do_malformed) begin
        run_cnt <= '0;
      end
    end
  end

  // Edge tracking survives link_reset so a level held across it is not recounted.
  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n) skp_prev <= 1'b0;
    else          skp_prev <= err_skp_unexpected;
  end

  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n)                                                skp_err_cnt <= '0;
    else if (link_reset)                                         skp_err_cnt <= '0;
    else if (err_skp_unexpected && !skp_prev && !(&skp_err_cnt)) skp_err_cnt <= skp_err_cnt + CNT_ONE;
  end

endmodule

// File: tb/tb_usb3_rx_os_ctl.sv
// Bench for usb3_rx_os_ctl: directed test-plan steps plus randomized ordered-set
// traffic, all checked every cycle against a queue-based reference model.
module tb_usb3_rx_os_ctl;

  localparam int CNT_W      = 4;
  localparam int TS2_THRESH = 8;
  localparam int CNT_MAX    = 15;
  localparam logic [35:0] W0 = {4'hF, 32'hBCBCBCBC};

  logic             local_clk = 1'b0;
  logic             reset_n;
  logic [31:0]      proc_data;
  logic [3:0]       proc_datak;
  logic             proc_active;
  logic             err_skp_unexpected;
  logic             link_reset;
  logic             scr_enable, ts1_det, ts2_det;
  logic [7:0]       link_func;
  logic [CNT_W-1:0] run_cnt, skp_err_cnt;

  always #5 local_clk = ~local_clk;

  usb3_rx_os_ctl #(.TS2_THRESH(TS2_THRESH), .CNT_W(CNT_W)) dut (
    .local_clk(local_clk), .reset_n(reset_n), .proc_data(proc_data),
    .proc_datak(proc_datak), .proc_active(proc_active),
    .err_skp_unexpected(err_skp_unexpected), .link_reset(link_reset),
    .scr_enable(scr_enable), .ts1_det(ts1_det), .ts2_det(ts2_det),
    .link_func(link_func), .run_cnt(run_cnt), .skp_err_cnt(skp_err_cnt)
  );

  int n_asserts = 0;
  int n_fail    = 0;
  logic skp_v  = 1'b0;
  logic lrst_v = 1'b0;

  // Reference model: words of the set in progress, plus expected output values.
  logic [35:0] buf_q[$];
  logic [7:0]  m_ident_prev, m_func;
  int          m_run, m_skp;
  logic        m_scr, m_skp_prev, exp_ts1, exp_ts2;

  function automatic logic [35:0] mk_w1(input logic [7:0] ident, input logic [7:0] func);
    return {4'h0, ident, ident, func, 8'h00};
  endfunction

  function automatic logic [35:0] mk_body(input logic [7:0] ident);
    return {4'h0, ident, ident, ident, ident};
  endfunction

  task automatic model_reset(input logic full);
    buf_q.delete();
    m_ident_prev = 8'h00; m_func = 8'h00; m_run = 0; m_skp = 0;
    m_scr = 1'b1; exp_ts1 = 1'b0; exp_ts2 = 1'b0;
    if (full) m_skp_prev = 1'b0;
  endtask

  function automatic logic word_ok(input int idx, input logic [35:0] wd, input logic [7:0] ident);
    if (idx == 1)
      return wd[35:32] == 4'h0 && wd[7:0] == 8'h00 && wd[23:16] == wd[31:24] &&
             (wd[31:24] == 8'h4A || wd[31:24] == 8'h45);
    return wd == mk_body(ident);
  endfunction

  task automatic model_clock(input logic [35:0] wd, input logic act);
    logic [7:0] ident, func;
    int n;
    exp_ts1 = 1'b0; exp_ts2 = 1'b0;
    if (lrst_v) begin
      model_reset(1'b0);
      m_skp_prev = skp_v;
      return;
    end
    if (skp_v && !m_skp_prev && m_skp < CNT_MAX) m_skp++;
    m_skp_prev = skp_v;
    if (!act) return;
    n = buf_q.size();
    if (n == 0) begin
      if (wd == W0) buf_q.push_back(wd);
    end else begin
      ident = (n > 1) ? buf_q[1][31:24] : 8'h00;
      if (word_ok(n, wd, ident)) begin
        buf_q.push_back(wd);
        if (buf_q.size() == 4) begin
          ident = buf_q[1][31:24];
          func  = buf_q[1][15:8];
          if (ident == m_ident_prev && func == m_func) m_run = (m_run < CNT_MAX) ? m_run + 1 : CNT_MAX;
          else m_run = 1;
          m_func = func; m_ident_prev = ident;
          exp_ts1 = (ident == 8'h4A);
          exp_ts2 = (ident == 8'h45);
          if (exp_ts2 && func[3] && m_run >= TS2_THRESH) m_scr = 1'b0;
          buf_q.delete();
        end
      end else if (!(n == 1 && wd == W0)) begin
        m_run = 0;
        buf_q.delete();
        if (wd == W0) buf_q.push_back(wd);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("scr_enable",  32'(scr_enable),  32'(m_scr));
    chk("ts1_det",     32'(ts1_det),     32'(exp_ts1));
    chk("ts2_det",     32'(ts2_det),     32'(exp_ts2));
    chk("link_func",   32'(link_func),   32'(m_func));
    chk("run_cnt",     32'(run_cnt),     32'(m_run));
    chk("skp_err_cnt", 32'(skp_err_cnt), 32'(m_skp));
  endtask

  task automatic step(input logic [35:0] wd, input logic act);
    proc_data = wd[31:0]; proc_datak = wd[35:32]; proc_active = act;
    err_skp_unexpected = skp_v; link_reset = lrst_v;
    model_clock(wd, act);
    @(posedge local_clk); #1;
    check_all();
  endtask

  task automatic send_set(input logic [35:0] a, input logic [35:0] b, input logic [35:0] c,
                          input logic [35:0] d, input int gpos, input int glen);
    logic [35:0] ws[4];
    ws[0] = a; ws[1] = b; ws[2] = c; ws[3] = d;
    for (int i = 0; i < 4; i++) begin
      step(ws[i], 1'b1);
      if (i == gpos) repeat (glen) step({4'($urandom), 32'($urandom)}, 1'b0);
    end
  endtask

  task automatic send_ts(input logic [7:0] ident, input logic [7:0] func);
    send_set(W0, mk_w1(ident, func), mk_body(ident), mk_body(ident), -1, 0);
  endtask

  task automatic pulse_link_reset();
    lrst_v = 1'b1; step(36'h0, 1'b0); lrst_v = 1'b0;
  endtask

  initial begin
    logic [7:0] funcs[4];
    logic [7:0] cur_ident, cur_func;
    logic [35:0] ws[4];
    funcs[0] = 8'h08; funcs[1] = 8'h08; funcs[2] = 8'h00; funcs[3] = 8'h0C;

    reset_n = 1'b0; proc_data = '0; proc_datak = '0; proc_active = 1'b0;
    err_skp_unexpected = 1'b0; link_reset = 1'b0;
    model_reset(1'b1);
    repeat (2) @(posedge local_clk);
    #1 reset_n = 1'b1;
    check_all();

    // 8 identical TS2 with disable scrambling.
    for (int i = 1; i <= 8; i++) begin
      send_ts(8'h45, 8'h08);
      chk("tp1_ts2_det", 32'(ts2_det), 32'd1);
      chk("tp1_run_cnt", 32'(run_cnt), 32'(i));
      chk("tp1_scr", 32'(scr_enable), (i == 8) ? 32'd0 : 32'd1);
    end
    step(36'h0, 1'b0);
    chk("tp1_pulse_width", 32'(ts2_det), 32'd0);

    // 7 TS2, TS1, 8 TS2.
    pulse_link_reset();
    chk("tp2_scr_after_lrst", 32'(scr_enable), 32'd1);
    repeat (7) send_ts(8'h45, 8'h08);
    send_ts(8'h4A, 8'h08);
    chk("tp2_ts1_run", 32'(run_cnt), 32'd1);
    chk("tp2_ts1_det", 32'(ts1_det), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      send_ts(8'h45, 8'h08);
      chk("tp2_run", 32'(run_cnt), 32'(i));
      chk("tp2_scr", 32'(scr_enable), (i == 8) ? 32'd0 : 32'd1);
    end
    send_ts(8'h4A, 8'h00);
    chk("tp2_ts1_no_reenable", 32'(scr_enable), 32'd0);

    // Corrupted body byte, then a clean TS1.
    pulse_link_reset();
    send_ts(8'h45, 8'h08);
    send_set(W0, mk_w1(8'h45, 8'h08), {4'h0, 32'h45454645}, mk_body(8'h45), -1, 0);
    chk("tp3_no_det", 32'(ts2_det), 32'd0);
    chk("tp3_run_zero", 32'(run_cnt), 32'd0);
    send_ts(8'h4A, 8'h01);
    chk("tp3_ts1_det", 32'(ts1_det), 32'd1);
    chk("tp3_run_one", 32'(run_cnt), 32'd1);
    chk("tp3_link_func", 32'(link_func), 32'h01);

    // Three idle cycles between W1 and W2.
    send_set(W0, mk_w1(8'h45, 8'h04), mk_body(8'h45), mk_body(8'h45), 1, 3);
    chk("tp4_gap_det", 32'(ts2_det), 32'd1);
    chk("tp4_gap_func", 32'(link_func), 32'h04);

    // link_reset coincident with W3 after scrambling is off.
    pulse_link_reset();
    repeat (8) send_ts(8'h45, 8'h08);
    chk("tp5_scr_off", 32'(scr_enable), 32'd0);
    step(W0, 1'b1); step(mk_w1(8'h45, 8'h08), 1'b1); step(mk_body(8'h45), 1'b1);
    lrst_v = 1'b1; step(mk_body(8'h45), 1'b1); lrst_v = 1'b0;
    chk("tp5_lrst_scr", 32'(scr_enable), 32'd1);
    chk("tp5_lrst_run", 32'(run_cnt), 32'd0);
    chk("tp5_lrst_det", 32'(ts2_det), 32'd0);

    // Async reset in the middle of a set.
    send_ts(8'h45, 8'h08);
    step(W0, 1'b1); step(mk_w1(8'h45, 8'h08), 1'b1);
    proc_active = 1'b0;
    reset_n = 1'b0;
    #1;
    model_reset(1'b1);
    check_all();
    chk("tp5_async_run", 32'(run_cnt), 32'd0);
    @(posedge local_clk); #1;
    reset_n = 1'b1;
    step(mk_body(8'h45), 1'b1); step(mk_body(8'h45), 1'b1);
    chk("tp5_resume_no_det", 32'(ts2_det), 32'd0);

    // SKP errors: held level counts once, then pulses saturate.
    skp_v = 1'b1;
    repeat (5) step(36'h0, 1'b0);
    chk("tp6_skp_level", 32'(skp_err_cnt), 32'd1);
    skp_v = 1'b0; step(36'h0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      skp_v = 1'b1; step(36'h0, 1'b0);
      skp_v = 1'b0; step(36'h0, 1'b0);
    end
    chk("tp6_skp_sat", 32'(skp_err_cnt), 32'd15);
    pulse_link_reset();
    chk("tp6_skp_clr", 32'(skp_err_cnt), 32'd0);

    // Randomized traffic.
    cur_ident = 8'h45; cur_func = 8'h08;
    for (int it = 0; it < 500; it++) begin
      int r;
      r = $urandom_range(0, 11);
      skp_v = ($urandom_range(0, 5) == 0);
      if (r == 0) begin
        repeat ($urandom_range(1, 3)) step({4'($urandom), 32'($urandom)}, 1'b0);
      end else if (r == 1) begin
        step({4'($urandom), 32'($urandom)}, 1'b1);
      end else if (r == 2 && $urandom_range(0, 3) == 0) begin
        lrst_v = 1'b1; step(W0, 1'b1); lrst_v = 1'b0;
      end else begin
        if (r == 3) step(W0, 1'b1);
        if ($urandom_range(0, 99) < 20) begin
          cur_ident = ($urandom_range(0, 3) == 0) ? 8'h4A : 8'h45;
          cur_func  = funcs[$urandom_range(0, 3)];
        end
        ws[0] = W0; ws[1] = mk_w1(cur_ident, cur_func);
        ws[2] = mk_body(cur_ident); ws[3] = mk_body(cur_ident);
        if ($urandom_range(0, 5) == 0) begin
          int idx;
          idx = $urandom_range(0, 3);
          if ($urandom_range(0, 3) == 0) ws[idx] = W0;
          else ws[idx] = ws[idx] ^ (36'd1 << $urandom_range(0, 35));
        end
        send_set(ws[0], ws[1], ws[2], ws[3],
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : -1, $urandom_range(1, 3));
      end
    end
    skp_v = 1'b0;
    step(36'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/usb3_rx_os_ctl.md
Name: usb3_rx_os_ctl

Overview:
- RX-side ordered-set controller after the descrambler stage; consumes its 32-bit/4-symbol output.
- Parses TS1/TS2 training ordered sets and counts consecutive identical sets.
- Drives the descrambler `enable` input; scrambling turns off only after a qualified run of TS2 sets with Disable Scrambling set.
- Reports detections, latched link-functionality byte and an SKP error count to the LTSSM.

Parameters:
- TS2_THRESH, 8: consecutive identical TS2 with Disable Scrambling required to deassert `scr_enable`.
- CNT_W, 4: width of the run counter and the SKP error counter; both saturate.

Ports:
- local_clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- proc_data  in  32  descrambled symbols; [7:0] is the earliest symbol.
- proc_datak  in  4  K flag per symbol.
- proc_active  in  1  word valid.
- err_skp_unexpected  in  1  level from descrambler; rising edge is one error.
- link_reset  in  1  synchronous restart from LTSSM.
- scr_enable  out  1  to descrambler `enable`.
- ts1_det  out  1  1-cycle pulse, valid TS1 parsed.
- ts2_det  out  1  1-cycle pulse, valid TS2 parsed.
- link_func  out  8  symbol 5 of the last valid TS.
- run_cnt  out  CNT_W  consecutive identical TS count.
- skp_err_cnt  out  CNT_W  saturating SKP error count.

Behaviour:
- Reset (async, or sync `link_reset`):
  - scr_enable=1; ts1_det=ts2_det=0; link_func=0; run_cnt=0; skp_err_cnt=0; state=IDLE.
  - Reset deasserts synchronously to local_clk.
- Ordered-set format, 4 words, word-aligned only:
  - W0: data 32'hBCBCBCBC with datak 4'b1111.
  - W1: datak 0; [7:0]=8'h00; [15:8]=link function; [23:16] and [31:24] = ident.
  - W2 and W3: datak 0; all four bytes = ident.
  - ident 8'h4A = TS1, 8'h45 = TS2.
  - Link function bits: [0] hot reset, [2] loopback, [3] disable scrambling.
- FSM advances only on proc_active=1 cycles:
  - IDLE: W0 match -> HDR.
  - HDR: W1 valid with ident TS1/TS2 -> capture ident and link function -> BODY1. W0 match again -> stay HDR. Any other word -> IDLE, malformed.
  - BODY1: W2 matches captured ident -> BODY2; else malformed.
  - BODY2: W3 matches -> classify, return to IDLE; else malformed.
  - On malformed: if the word is W0 go to HDR, otherwise go to IDLE.
- Classify, registered outputs appear on the cycle after W3 is sampled (latency 1):
  - Pulse ts1_det or ts2_det for 1 cycle.
  - link_func <= captured byte.
  - If ident and link_func equal the previous valid TS, run_cnt increments, saturating at 2^CNT_W-1. Otherwise run_cnt <= 1.
- Malformed set: run_cnt <= 0. No detect pulse; link_func unchanged.
- proc_active=0 mid-set: state holds, parse resumes. Gaps do not abort.
- Scrambling decision:
  - If a TS2 is classified with link_func[3]=1 and the updated run_cnt >= TS2_THRESH, scr_enable <= 0 on the same edge as ts2_det.
  - scr_enable then stays latched at 0; only reset_n or link_reset set it back to 1.
  - A TS1 or malformed set never re-enables it.
- skp_err_cnt: increments on each 0->1 transition of err_skp_unexpected; saturates; cleared by reset or link_reset.
- Simultaneous events:
  - link_reset in the same cycle as W3 classification: link_reset wins; no pulse; all outputs take reset values.
  - SKP error edge concurrent with anything: counted independently.
- run_cnt uses the post-increment value for the threshold compare, with no extra cycle.

Test Plan:
- 8 identical TS2, link func 8'h08, contiguous -> ts2_det pulses 8x; run_cnt 1..8; scr_enable falls on the 8th ts2_det edge.
- 7 TS2 (8'h08), 1 TS1, then 8 TS2 (8'h08) -> run_cnt resets to 1 at the TS1 and again at the first following TS2; scr_enable falls only after the final 8th TS2.
- TS2 with W2 byte 8'h46 -> no ts2_det; run_cnt=0. Next clean TS1 parses normally, run_cnt=1.
- proc_active low for 3 cycles between W1 and W2 -> set still detected; pulse 1 cycle after W3.
- After scr_enable=0, assert link_reset in the same cycle as a W3 -> scr_enable=1; run_cnt=0; no pulse. Async reset_n mid-set -> immediate reset values.
- err_skp_unexpected held high 5 cycles, then 20 separate 1-cycle pulses -> skp_err_cnt counts 1 for the held level, then saturates at 15.
